uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter.
- Accepts words over a valid/ready handshake.
- Serialises each word as: start bit, 5..MAX_DATA_BITS data bits LSB-first, optional even/odd parity bit, 1 or 2 stop bits.
- Bit period is set by a runtime divisor.
- Sits behind the AXI4-Lite register block, which drives the cfg_* fields and the s_* stream.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and helpers for the configurable UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int MIN_DATA_BITS = 5;

  function automatic logic [31:0] eff_div(input logic [31:0] cfg_div,
                                          input logic [31:0] clks_per_bit);
    return (cfg_div == 32'd0) ? clks_per_bit : cfg_div;
  endfunction

  // Even parity of the low nbits of data, flipped when odd sense is requested.
  function automatic logic calc_parity(input logic [15:0] data,
                                       input logic [3:0]  nbits,
                                       input logic        odd);
    logic p;
    p = odd;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(nbits)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Bit-period down-counter; bit_tick marks the last clock of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             active,
  input  logic [DIV_W-1:0] reload_div,
  output logic             bit_tick
);

  localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;

  assign bit_tick = active && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_div - C_ONE;
    end else if (bit_tick) begin
      r_cnt <= reload_div - C_ONE;
    end else if (active) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Brief    : Runtime-configurable UART transmitter (5..MAX_DATA_BITS, parity,
//            1/2 stop bits, runtime divisor). Define UART_TX_CTS_EN to add a
//            synchronised active-low cts_n flow-control input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ    = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef UART_TX_CTS_EN
  input  logic                     cts_n,
`endif
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [MAX_DATA_BITS-1:0] s_data,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  input  logic [DIV_W-1:0]         cfg_div,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int         CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [3:0] C_MIN_BITS   = 4'(MIN_DATA_BITS);
  localparam logic [3:0] C_MAX_BITS   = 4'(MAX_DATA_BITS);

  uart_state_t              r_state;
  uart_state_t              w_next;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic [3:0]               r_nbits;
  logic [3:0]               r_bit_idx;
  logic                     r_par_en;
  logic                     r_par;
  logic                     r_stop2;
  logic                     r_done;
  logic [DIV_W-1:0]         r_div;
  logic [DIV_W-1:0]         w_div_eff;
  logic [3:0]               w_nbits;
  logic                     w_accept;
  logic                     w_tick;
  logic                     w_last_data;
  logic                     w_last_stop;
  logic                     w_clear;

`ifdef UART_TX_CTS_EN
  logic r_cts_meta;
  logic r_cts_sync;

  // Synchroniser resets to "not clear" so nothing is sent before cts_n is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_clear = !r_cts_sync;
`else
  assign w_clear = 1'b1;
`endif

  assign w_nbits = (cfg_data_bits < C_MIN_BITS) ? C_MIN_BITS :
                   (cfg_data_bits > C_MAX_BITS) ? C_MAX_BITS : cfg_data_bits;
  assign w_div_eff   = DIV_W'(eff_div(32'(cfg_div), 32'(CLKS_PER_BIT)));
  assign w_accept    = s_valid && s_ready;
  assign w_last_data = (r_bit_idx == (r_nbits - 4'd1));
  assign w_last_stop = (r_bit_idx == {3'b000, r_stop2});
  assign busy        = (r_state != IDLE);
  assign tx_done     = r_done;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_accept),
    .load_div   (w_div_eff),
    .active     (busy),
    .reload_div (r_div),
    .bit_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    tx      = 1'b1;
    case (r_state)
      IDLE: begin
        s_ready = w_clear;
        if (s_valid && w_clear) w_next = START;
      end
      START: begin
        tx = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_tick && w_last_data) w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx = r_par;
        if (w_tick) w_next = STOP;
      end
      STOP: begin
        if (w_tick && w_last_stop) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame configuration is captured on accept so later cfg changes wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_nbits   <= '0;
      r_bit_idx <= '0;
      r_par_en  <= 1'b0;
      r_par     <= 1'b0;
      r_stop2   <= 1'b0;
      r_div     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_tick && w_last_stop;
      if (w_accept) begin
        r_shift   <= s_data;
        r_nbits   <= w_nbits;
        r_bit_idx <= '0;
        r_par_en  <= cfg_parity_en;
        r_par     <= calc_parity(16'(s_data), w_nbits, cfg_parity_odd);
        r_stop2   <= cfg_stop2;
        r_div     <= w_div_eff;
      end else if (w_tick) begin
        if (r_state == DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
        end else if (r_state == STOP) begin
          r_bit_idx <= w_last_stop ? 4'd0 : r_bit_idx + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Brief    : Self-checking bench: waveform-level frame model plus literal frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [8:0]  s_data = '0;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_parity_odd = 1'b0;
  logic        cfg_stop2 = 1'b0;
  logic [15:0] cfg_div = 16'd4;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_cfg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .cfg_div        (cfg_div),
    .tx             (tx),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endfunction

  // Model: the line level of every remaining clock of the frame in flight.
  bit q[$];
  bit exp_done = 1'b0;

  function automatic void build_frame(input logic [8:0] d, input logic [3:0] nb,
                                      input logic pe, input logic po,
                                      input logic s2, input logic [15:0] dv);
    int n;
    int div;
    bit p;
    bit bits[$];
    n   = (nb < 5) ? 5 : ((nb > 9) ? 9 : int'(nb));
    div = (dv == 16'd0) ? 5208 : int'(dv);
    p   = po;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) bits.push_back(p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) repeat (div) q.push_back(bits[k]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_done = 1'b1;
      end else if (s_valid) begin
        build_frame(s_data, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2, cfg_div);
      end
    end
  end

  always @(negedge clk) begin
    bit in_frame;
    in_frame = (q.size() > 0);
    chk("tx",      int'(tx),      in_frame ? int'(q[0]) : 1);
    chk("busy",    int'(busy),    int'(in_frame));
    chk("s_ready", int'(s_ready), int'(!in_frame));
    chk("tx_done", int'(tx_done), int'(exp_done));
  end

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!s_ready && w < 200) begin
      @(posedge clk); #2;
      w++;
    end
    if (!s_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_literal(input string name, input logic [8:0] d, input logic [3:0] nb,
                             input logic pe, input logic po, input logic s2, input int dv,
                             input int exp_len, input logic [15:0] exp_pat);
    logic [15:0] cap;
    int busy_cnt;
    int done_at;
    cap = '0;
    busy_cnt = 0;
    done_at = 0;
    @(posedge clk); #2;
    s_data = d; cfg_data_bits = nb; cfg_parity_en = pe; cfg_parity_odd = po;
    cfg_stop2 = s2; cfg_div = 16'(dv); s_valid = 1'b1;
    wait_ready(name);
    @(posedge clk); #2;
    s_valid = 1'b0;
    s_data  = ~d;
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (tx_done && done_at == 0) done_at = c;
      if (c <= exp_len && ((c - 1) % dv) == (dv - 1) / 2) cap[(c - 1) / dv] = tx;
      @(posedge clk); #2;
    end
    chk({name, "_pattern"}, int'(cap), int'(exp_pat));
    chk({name, "_busy_len"}, busy_cnt, exp_len);
    chk({name, "_done_cycle"}, done_at, exp_len + 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d1;
    int d2;
    int low;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx",      int'(tx),      1);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_s_ready", int'(s_ready), 1);
    chk("reset_tx_done", int'(tx_done), 0);
    #1 rst_n = 1'b1;

    run_literal("8N1_55",  9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 4, 40, 16'h02AA);
    run_literal("7E2_41",  9'h041, 4'd7, 1'b1, 1'b0, 1'b1, 3, 33, 16'h0682);
    run_literal("9O1_1FF", 9'h1FF, 4'd9, 1'b1, 1'b1, 1'b0, 2, 24, 16'h0BFE);
    run_literal("9O1_0FF", 9'h0FF, 4'd9, 1'b1, 1'b1, 1'b0, 2, 24, 16'h0DFE);

    // Back-to-back with a divisor change during the first frame.
    @(posedge clk); #2;
    s_data = 9'h0A5; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    cfg_div = 16'd2; s_valid = 1'b1;
    wait_ready("b2b");
    @(posedge clk); #2;
    s_data = 9'h03C;
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (tx_done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 21) chk("b2b_gap_high", int'(tx), 1);
      if (c == 22) chk("b2b_second_start", int'(tx), 0);
      @(posedge clk); #2;
      if (c == 5) cfg_div = 16'd5;
      if (d1 != 0) s_valid = 1'b0;
    end
    chk("b2b_done1", d1, 21);
    chk("b2b_done2", d2, 72);

    // Asynchronous reset inside the 4th data bit.
    @(posedge clk); #2;
    s_data = 9'h055; cfg_div = 16'd4; s_valid = 1'b1;
    wait_ready("rst");
    @(posedge clk); #2;
    s_valid = 1'b0;
    repeat (17) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_tx",      int'(tx),      1);
    chk("midrst_busy",    int'(busy),    0);
    chk("midrst_s_ready", int'(s_ready), 1);
    chk("midrst_tx_done", int'(tx_done), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_literal("after_rst_55", 9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 4, 40, 16'h02AA);

    // Default divisor: measure the start bit, then abort with reset.
    @(posedge clk); #2;
    s_data = 9'h01F; cfg_data_bits = 4'd5; cfg_div = 16'd0; s_valid = 1'b1;
    wait_ready("div0");
    @(posedge clk); #2;
    s_valid = 1'b0;
    low = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (tx) break;
      low++;
    end
    chk("div0_start_len", low, 5208);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomised traffic: every input may change every cycle, including mid-frame.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      s_valid        = ($urandom_range(0, 3) != 0);
      s_data         = 9'($urandom);
      cfg_data_bits  = 4'($urandom_range(0, 15));
      cfg_parity_en  = 1'($urandom);
      cfg_parity_odd = 1'($urandom);
      cfg_stop2      = 1'($urandom);
      cfg_div        = 16'($urandom_range(1, 4));
    end
    s_valid = 1'b0;
    repeat (80) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
